// File: rtl/contador_pkg.sv
// ============================================================================
// Module  : contador_pkg
// Purpose : Shared types and constants for the contador register arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package contador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Word indices of the contador slave registers
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 255;

    function automatic logic [1:0] rr_next(input logic [1:0] id, input int n);
        if (int'(id) + 1 >= n) return 2'd0;
        return id + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_rr_pick.sv
// ============================================================================
// Module  : contador_rr_pick
// Purpose : Combinational round-robin search for the first set request bit,
//           starting at the pointer and wrapping modulo NUM_REQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    logic [3:0] w_req_pad;
    logic [1:0] w_pos;

    assign w_req_pad = 4'(req_i);

    // Scan from the farthest offset down so the nearest hit is written last
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 2'd0;
        w_pos   = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = 2'((int'(ptr_i) + i) % NUM_REQ);
            if (w_req_pad[w_pos]) begin
                valid_o = 1'b1;
                idx_o   = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/contador_reg_arbiter.sv
// ============================================================================
// Module  : contador_reg_arbiter
// Purpose : Round-robin scheduler sharing the contador register port between
//           NUM_REQ requesters, with per-access timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_reg_arbiter
    import contador_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_err,
    output logic                          m_valid,
    output logic                          m_we,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic                          m_ack,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    output logic                          busy,
    output logic [1:0]                    grant_id
);

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              grant_q, grant_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    w_pick_valid;
    logic [1:0]              w_pick_idx;
    logic [3:0]              w_we_pad;
    logic [3:0]              w_ack_onehot;

    contador_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    assign w_we_pad     = 4'(req_we);
    assign w_ack_onehot = 4'b0001 << grant_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (w_pick_valid) begin
                    grant_d = w_pick_idx;
                    we_d    = w_we_pad[w_pick_idx];
                    addr_d  = req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                // An ack arriving on the expiry cycle still wins
                if (m_ack) begin
                    rdata_d = we_q ? '0 : m_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                ptr_d   = rr_next(grant_q, NUM_REQ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_valid   = (state_q == ISSUE);
    assign m_we      = we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
    assign req_ack   = (state_q == DONE) ? w_ack_onehot[NUM_REQ-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_contador_reg_arbiter.sv
// ============================================================================
// Module  : tb_contador_reg_arbiter
// Purpose : Self-checking bench for contador_reg_arbiter (NUM_REQ=2, TIMEOUT=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_reg_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [1:0]  req_valid, req_we;
    logic [3:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ack;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        m_valid, m_we;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        busy;
    logic [1:0]  grant_id;

    int n_cmp = 0;
    int n_err = 0;

    // Slave environment: acks after slave_delay ISSUE cycles (>=8 never acks)
    logic [31:0] mem [4];
    logic [31:0] model_mem [4];
    int          slave_delay = 0;
    bit          stray = 1'b0;
    int          vcnt = 0;

    always #5 ACLK = ~ACLK;

    contador_reg_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .grant_id(grant_id)
    );

    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge ACLK);
            m_ack   = 1'b0;
            m_rdata = '0;
            if (m_valid === 1'b1) begin
                if (vcnt == slave_delay) begin
                    m_ack = 1'b1;
                    if (m_we) mem[m_addr] = m_wdata;
                    else      m_rdata = mem[m_addr];
                end
                vcnt++;
            end else begin
                vcnt = 0;
                if (stray) m_ack = 1'b1;
            end
        end
    end

    task automatic set_req(input int r, input logic we, input logic [1:0] a, input logic [31:0] d);
        req_we[r]          = we;
        req_addr[r*2 +: 2]  = a;
        req_wdata[r*32 +: 32] = d;
    endtask

    task automatic wait_ack(output int idx, output bit got);
        got = 1'b0;
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            if (req_ack !== 2'b00) begin
                got = 1'b1;
                idx = (req_ack === 2'b01) ? 0 : (req_ack === 2'b10) ? 1 : 9;
                break;
            end
        end
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge ACLK);
        n_cmp++;
        if ({m_valid, busy, req_ack, req_err, grant_id} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b want 000000", {m_valid, busy, req_ack, req_err, grant_id});
            n_err++;
        end
        n_cmp++;
        if ({m_we, m_addr, m_wdata, req_rdata} !== '0) begin
            $display("FAIL reset_data: got %h want 0", {m_we, m_addr, m_wdata, req_rdata});
            n_err++;
        end
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_write;
        int nv;
        bit bad;
        set_req(0, 1'b1, 2'd1, 32'h5);
        slave_delay = 1;
        req_valid = 2'b01;
        @(negedge ACLK);
        nv = 0; bad = 1'b0;
        while (m_valid === 1'b1 && nv < 20) begin
            if (m_addr !== 2'd1 || m_wdata !== 32'h5 || m_we !== 1'b1) bad = 1'b1;
            nv++;
            @(negedge ACLK);
        end
        req_valid = 2'b00;
        n_cmp++;
        if (nv !== 2 || bad) begin
            $display("FAIL write_issue: got cycles=%0d badfields=%0d want cycles=2 badfields=0", nv, bad);
            n_err++;
        end
        n_cmp++;
        if (req_ack !== 2'b01 || req_err !== 1'b0) begin
            $display("FAIL write_ack: got ack=%b err=%b want ack=01 err=0", req_ack, req_err);
            n_err++;
        end
        @(negedge ACLK);
        n_cmp++;
        if (req_ack !== 2'b00 || req_err !== 1'b0) begin
            $display("FAIL write_ack_pulse: got ack=%b err=%b want ack=00 err=0", req_ack, req_err);
            n_err++;
        end
    endtask

    task automatic test_read;
        int idx; bit got;
        mem[2] = 32'h2A;
        set_req(1, 1'b0, 2'd2, 32'h0);
        slave_delay = 0;
        req_valid = 2'b10;
        wait_ack(idx, got);
        req_valid = 2'b00;
        n_cmp++;
        if (!got || idx !== 1 || req_rdata !== 32'h2A || req_err !== 1'b0 || grant_id !== 2'd1) begin
            $display("FAIL read: got ack=%0d idx=%0d rdata=%h err=%b gid=%0d want 1 1 0000002a 0 1",
                     got, idx, req_rdata, req_err, grant_id);
            n_err++;
        end
    endtask

    task automatic test_rotation;
        int order[4];
        int when[4];
        int k, t;
        ARESET = 1'b1;
        set_req(0, 1'b0, 2'd0, 32'h0);
        set_req(1, 1'b0, 2'd3, 32'h0);
        req_valid = 2'b11;
        slave_delay = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
        k = 0; t = 0;
        while (k < 4 && t < 60) begin
            @(negedge ACLK);
            t++;
            if (req_ack !== 2'b00) begin
                order[k] = (req_ack === 2'b01) ? 0 : (req_ack === 2'b10) ? 1 : 9;
                when[k]  = t;
                k++;
            end
        end
        req_valid = 2'b00;
        n_cmp++;
        if (k !== 4) begin
            $display("FAIL rotation_count: got %0d acks want 4", k);
            n_err++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (order[i] !== (i % 2)) begin
                    $display("FAIL rotation_order[%0d]: got %0d want %0d", i, order[i], i % 2);
                    n_err++;
                end
            end
            n_cmp++;
            if (when[1] - when[0] !== 3 || when[2] - when[1] !== 3 || when[3] - when[2] !== 3) begin
                $display("FAIL rotation_period: got %0d %0d %0d want 3 3 3",
                         when[1] - when[0], when[2] - when[1], when[3] - when[2]);
                n_err++;
            end
        end
        @(negedge ACLK);
    endtask

    task automatic test_timeout;
        int nv, idx; bit got;
        set_req(0, 1'b0, 2'd3, 32'h0);
        slave_delay = 255;
        req_valid = 2'b01;
        @(negedge ACLK);
        nv = 0;
        while (m_valid === 1'b1 && nv < 40) begin
            nv++;
            @(negedge ACLK);
        end
        req_valid = 2'b00;
        n_cmp++;
        if (nv !== 8) begin
            $display("FAIL timeout_len: got %0d cycles want 8", nv);
            n_err++;
        end
        n_cmp++;
        if (req_ack !== 2'b01 || req_err !== 1'b1 || req_rdata !== 32'h0) begin
            $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h want 01 1 00000000", req_ack, req_err, req_rdata);
            n_err++;
        end
        set_req(0, 1'b0, 2'd2, 32'h0);
        slave_delay = 0;
        req_valid = 2'b01;
        wait_ack(idx, got);
        req_valid = 2'b00;
        n_cmp++;
        if (!got || idx !== 0 || req_err !== 1'b0 || req_rdata !== 32'h2A) begin
            $display("FAIL after_timeout: got ack=%0d idx=%0d err=%b rdata=%h want 1 0 0 0000002a",
                     got, idx, req_err, req_rdata);
            n_err++;
        end
        @(negedge ACLK);
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            n_cmp++;
            if (busy !== 1'b0 || req_ack !== 2'b00) begin
                $display("FAIL stray_ack: got busy=%b ack=%b want 0 00", busy, req_ack);
                n_err++;
            end
        end
        stray = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_hold_fields;
        int nv; bit bad;
        set_req(0, 1'b0, 2'd1, 32'h0);
        slave_delay = 3;
        req_valid = 2'b01;
        @(negedge ACLK);
        req_addr[1:0] = 2'd3;
        req_we[0]     = 1'b1;
        req_valid     = 2'b00;
        nv = 0; bad = 1'b0;
        while (m_valid === 1'b1 && nv < 20) begin
            if (m_addr !== 2'd1 || m_we !== 1'b0) bad = 1'b1;
            nv++;
            @(negedge ACLK);
        end
        n_cmp++;
        if (bad || nv !== 4) begin
            $display("FAIL hold_fields: got cycles=%0d badfields=%0d want 4 0", nv, bad);
            n_err++;
        end
        n_cmp++;
        if (req_ack !== 2'b01 || req_rdata !== 32'h5) begin
            $display("FAIL hold_result: got ack=%b rdata=%h want 01 00000005", req_ack, req_rdata);
            n_err++;
        end
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid;
        int idx; bit got;
        set_req(1, 1'b0, 2'd0, 32'h0);
        slave_delay = 255;
        req_valid = 2'b10;
        repeat (4) @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || req_ack !== 2'b00 || grant_id !== 2'd0) begin
            $display("FAIL reset_mid: got mv=%b busy=%b ack=%b gid=%0d want 0 0 00 0", m_valid, busy, req_ack, grant_id);
            n_err++;
        end
        set_req(0, 1'b0, 2'd1, 32'h0);
        req_valid = 2'b11;
        slave_delay = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
        wait_ack(idx, got);
        req_valid = 2'b00;
        n_cmp++;
        if (!got || idx !== 0) begin
            $display("FAIL reset_regrant: got ack=%0d idx=%0d want 1 0", got, idx);
            n_err++;
        end
        @(negedge ACLK);
    endtask

    task automatic test_random;
        int ptr, w, idx, c;
        bit got, exp_err;
        logic [1:0]  v;
        logic [31:0] exp_rd;
        ARESET = 1'b1;
        req_valid = 2'b00;
        for (int a = 0; a < 4; a++) begin
            mem[a] = $urandom;
            model_mem[a] = mem[a];
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        ptr = 0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++)
                set_req(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            v = 2'($urandom_range(1, 3));
            slave_delay = $urandom_range(0, 9);
            w = -1;
            for (int k = 1; k >= 0; k--) begin
                c = (ptr + k) % 2;
                if (v[c]) w = c;
            end
            exp_err = (slave_delay >= 8);
            if (exp_err || req_we[w]) exp_rd = 32'h0;
            else exp_rd = model_mem[req_addr[w*2 +: 2]];
            if (!exp_err && req_we[w]) model_mem[req_addr[w*2 +: 2]] = req_wdata[w*32 +: 32];
            ptr = (w + 1) % 2;
            req_valid = v;
            wait_ack(idx, got);
            req_valid = 2'b00;
            n_cmp++;
            if (!got || idx !== w || req_err !== exp_err || req_rdata !== exp_rd || grant_id !== 2'(w)) begin
                $display("FAIL random[%0d]: got ack=%0d idx=%0d err=%b rdata=%h gid=%0d want 1 %0d %b %h %0d",
                         it, got, idx, req_err, req_rdata, grant_id, w, exp_err, exp_rd, w);
                n_err++;
            end
            @(negedge ACLK);
            n_cmp++;
            if (req_ack !== 2'b00) begin
                $display("FAIL random_pulse[%0d]: got ack=%b want 00", it, req_ack);
                n_err++;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4; a++) mem[a] = '0;
        test_reset();
        test_write();
        test_read();
        test_rotation();
        test_timeout();
        test_hold_fields();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/contador_reg_arbiter.md
Name: contador_reg_arbiter

Overview:
Round-robin scheduler that shares the contador IP's single register-access port (4 x 32-bit slave registers) between NUM_REQ local requesters, such as the UART command decoder and the periodic status poller. It serialises one access at a time, holds the downstream command until acknowledged, and returns read data or a timeout error to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_WIDTH, 2, register word index width (4 registers)
DATA_WIDTH, 32, register data width
TIMEOUT, 255, max cycles waiting for m_ack before abort (1..65535)

Ports:
ACLK  in  1  system clock
ARESET  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester access request, held until its req_ack
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed word index per requester
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data per requester
req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
req_rdata  out  DATA_WIDTH  read data, valid with req_ack (shared)
req_err  out  1  timeout flag, valid with req_ack
m_valid  out  1  downstream command valid
m_we  out  1  downstream write enable
m_addr  out  ADDR_WIDTH  downstream word index
m_wdata  out  DATA_WIDTH  downstream write data
m_ack  in  1  downstream completion, one cycle
m_rdata  in  DATA_WIDTH  downstream read data, valid with m_ack
busy  out  1  high in any state other than IDLE
grant_id  out  2  index of current/last granted requester

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; rr pointer 0; timeout counter 0. Reset mid-access drops m_valid at once. No req_ack is generated for the aborted access.
- FSM: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE: if any req_valid is set, pick the first set bit scanning from rr pointer upward, wrapping modulo NUM_REQ. Register we/addr/wdata of the winner, set grant_id, go to ISSUE. m_valid rises the cycle after the request is seen (1-cycle latency).
- ISSUE: m_valid=1. m_we/m_addr/m_wdata hold the captured values stably. Counter increments each cycle.
  - On m_ack: capture m_rdata (writes: capture 0), req_err=0, go to DONE.
  - If the counter reaches TIMEOUT without m_ack: m_valid=0, rdata=0, req_err=1, go to DONE.
  - m_ack in the same cycle as expiry counts as success.
- DONE: req_ack[grant_id]=1 for exactly one cycle with req_rdata/req_err. rr pointer = grant_id+1 mod NUM_REQ. Counter clears. Return to IDLE; the next grant can be issued the cycle after DONE.
- Access throughput: minimum 3 cycles per access (IDLE, ISSUE with immediate m_ack, DONE).
- m_ack while not in ISSUE is ignored.
- Request fields are sampled only at grant. Later changes, or early deassertion of req_valid, do not alter the in-flight access.
- Simultaneous requests: strict rotation, so no requester waits more than NUM_REQ-1 accesses.
- req_rdata/req_err hold their last values outside DONE.
- grant_id holds its value after completion.

Decomposition:
- Package contador_pkg: state enum (IDLE, ISSUE, DONE), register index constants (REG_CTRL=0, REG_LOAD=1, REG_COUNT=2, REG_STATUS=3), default widths.
- Sub-module contador_rr_pick: combinational round-robin first-set search from the pointer. Returns a valid flag and index.

Test Plan:
- Reset, then requester 0 writes addr 1 data 0x00000005; slave acks 2 cycles after m_valid -> m_valid held 2 cycles with m_addr=1, m_wdata=5, m_we=1; req_ack=2'b01 one cycle later, req_err=0.
- Requester 1 reads addr 2; slave returns m_rdata=0x0000002A with m_ack -> req_ack=2'b10, req_rdata=0x2A.
- Both requesters assert continuously from reset -> grant order 0,1,0,1. Each req_ack pulses once per access, with a 3-cycle period when the slave acks immediately.
- Slave never acks, TIMEOUT=8 -> m_valid high 8 cycles then low; req_ack with req_err=1, req_rdata=0; next request proceeds normally.
- Requester 0 changes req_addr from 1 to 3 during ISSUE -> m_addr stays 1 until completion.
- ARESET asserted mid-ISSUE -> m_valid, busy and req_ack go to 0 immediately. After release, IDLE grants requester 0 first.
